// File: rtl/regfile.sv
// rtl/regfile.sv - general-purpose register file with write-to-read bypass
//
// Write-back sink of the pipeline. It takes the MEM/WB result on a single
// write port and serves the ID stage through two combinational read ports.
// Register 0 is hardwired to zero. A write in the current cycle is forwarded
// to the read ports, so a consumer three stages behind its producer reads the
// fresh value without stalling.
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    register address width
//   NUM_REGS  number of registers; must equal 2**ADDR_W
//
// Ports:
//   clk     in   1       pipeline clock, rising edge
//   rst     in   1       asynchronous reset, active-low
//   we      in   1       write enable (wb_wreg)
//   waddr   in   ADDR_W  write address (wb_wd)
//   wdata   in   DATA_W  write data (wb_wdata)
//   re1     in   1       read enable, port 1
//   raddr1  in   ADDR_W  read address, port 1
//   rdata1  out  DATA_W  read data, port 1
//   re2     in   1       read enable, port 2
//   raddr2  in   ADDR_W  read address, port 2
//   rdata2  out  DATA_W  read data, port 2

module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // A write only lands when it targets a real (non-zero) register; this
    // qualified enable is shared by the storage and both bypass paths.
    logic wr_live;
    assign wr_live = we && (waddr != '0);

    // Entry 0 is a constant, so no flop is built for it.
    assign regs[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs[g] <= '0;
                end else if (wr_live && (waddr == ADDR_W'(g))) begin
                    regs[g] <= wdata;
                end
            end
        end
    endgenerate

    // Port 1: reset and read-enable gate the output to zero; address 0 reads
    // zero from the constant entry, and wr_live already excludes it from the
    // bypass so a discarded write to r0 can never leak through.
    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            if (wr_live && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    // Port 2: identical selection, independent of port 1.
    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            if (wr_live && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule
